compress_pack: RTL and testbench

COMPRESS_PACK -- requirements
Module: compress_pack

---
 rtl/compress_pack.sv | 143 ++++++++++++++
 tb/tb_compress_pack.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_pack.sv
// compress_pack: Compress_q(x, D) with q = 3329 on a stream of 12-bit
// coefficients, followed by a little-endian bit packer that emits bytes.
// Every 256 coefficients form one block of 32*D bytes; the last byte of a
// block is flagged with out_last. Both sides use valid/ready handshakes.
module compress_pack #(
  parameter int D = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_coef,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last
);

  // Only these widths are defined for Compress_q in this design.
  if (!(D == 1 || D == 4 || D == 5 || D == 10 || D == 11)) begin : g_bad_d
    $error("compress_pack: D must be one of 1, 4, 5, 10, 11");
  end

  // ---------------------------------------------------------------------------
  // Exact constant division by 3329.
  // The numerator n = x*2^D + 1664 is below 2^NUM_W. With
  // RECIP = ceil(2^SHIFT / 3329) and SHIFT = NUM_W + 12, the product error
  // n * (RECIP - 2^SHIFT/3329) / 2^SHIFT is below 1/4096. The fractional part
  // of n/3329 never exceeds 3328/3329, so that error can never carry the
  // result across an integer: the floor is exact for every 12-bit x,
  // including raw inputs >= 3329.
  // ---------------------------------------------------------------------------
  localparam int Q       = 3329;
  localparam int HALF    = (Q - 1) / 2;
  localparam int NUM_W   = 13 + D;
  localparam int SHIFT   = NUM_W + 12;
  localparam int RECIP_W = SHIFT - 10;
  localparam int PROD_W  = NUM_W + RECIP_W;
  localparam logic [RECIP_W-1:0] RECIP =
    RECIP_W'(((64'd1 << SHIFT) + 64'(Q - 1)) / 64'(Q));

  // Block geometry: 256 coefficients * D bits = 32*D bytes, no padding.
  localparam int BLK_BYTES = 32 * D;
  localparam int BCNT_W    = $clog2(BLK_BYTES);

  logic [NUM_W-1:0]  num;
  logic [PROD_W-1:0] prod;
  logic [D-1:0]      c_next;

  // Stage C register: one compressed value waiting to enter the packer.
  logic              c_vld;
  logic [D-1:0]      c_val;

  // Packer state: bits [cnt-1:0] of pack_buf are valid, everything above is 0.
  logic [17:0]       pack_buf;
  logic [4:0]        cnt;
  logic [BCNT_W-1:0] byte_cnt;

  // Combinational next-state terms of the packer.
  logic              pop;
  logic              merge;
  logic              in_xfer;
  logic [4:0]        cnt_pop;
  logic [17:0]       buf_pop;
  logic [4:0]        cnt_next;
  logic [17:0]       buf_next;

  assign num    = (NUM_W'(in_coef) << D) + NUM_W'(HALF);
  assign prod   = PROD_W'(num) * PROD_W'(RECIP);
  // Taking the low D bits of the quotient is the "mod 2^D".
  assign c_next = D'(prod >> SHIFT);

  // Handshake and packer control. The outputs depend on registers only,
  // so they hold steady while the consumer stalls.
  assign out_valid = (cnt >= 5'd8);
  assign out_byte  = pack_buf[7:0];
  assign out_last  = out_valid && (byte_cnt == BCNT_W'(BLK_BYTES - 1));

  assign pop      = out_valid && out_ready;
  assign cnt_pop  = pop ? (cnt - 5'd8) : cnt;
  assign buf_pop  = pop ? (pack_buf >> 8) : pack_buf;
  assign merge    = c_vld && (cnt_pop < 5'd8);
  assign in_ready = !c_vld || merge;
  assign in_xfer  = in_valid && in_ready;

  // Next packer contents: apply the pop, then append c_val above the
  // remaining bits when stage C merges.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    cnt_next = cnt_pop;
    buf_next = buf_pop;
    if (merge) begin
      cnt_next = cnt_pop + 5'(D);
      buf_next = buf_pop | (18'(c_val) << cnt_pop);
    end
  end

  // Stage C valid flag: set on every accepted coefficient, cleared when
  // its value moves into the packer and nothing replaces it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      c_vld <= 1'b0;
    end else if (in_xfer) begin
      c_vld <= 1'b1;
    end else if (merge) begin
      c_vld <= 1'b0;
    end
  end

  // Stage C value: captured on every accepted coefficient.
  always_ff @(posedge clk) begin
    // NOTE: c_val is pure data qualified by c_vld, so it carries no reset;
    // its contents are never observed until c_vld is set again.
    if (in_xfer) begin
      c_val <= c_next;
    end
  end

  // Packer buffer and fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 5'd0;
      pack_buf <= 18'd0;
    end else begin
      cnt      <= cnt_next;
      pack_buf <= buf_next;
    end
  end

  // Byte position within the current block; wraps after the last byte so
  // consecutive blocks stream with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (pop) begin
      byte_cnt <= out_last ? '0 : byte_cnt + BCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_compress_pack.sv
// tb_compress_pack: drives five compress_pack instances (D = 10, 1, 4, 11, 5)
// one at a time. A bit-queue model computes the byte stream from the
// Compress_q formula and is compared with the selected instance every cycle;
// directed block tests pin the model with hand-computed bytes.
module tb_compress_pack;

  localparam int NI = 5;
  localparam int DS [NI] = '{10, 1, 4, 11, 5};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NI-1:0]        in_valid;
  logic [NI-1:0]        in_ready;
  logic [NI-1:0][11:0]  in_coef;
  logic [NI-1:0]        out_valid;
  logic [NI-1:0]        out_ready;
  logic [NI-1:0][7:0]   out_byte;
  logic [NI-1:0]        out_last;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    compress_pack #(.D(DS[g])) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_coef   (in_coef[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_byte  (out_byte[g]),
      .out_last  (out_last[g])
    );
  end

  int checks = 0;
  int errors = 0;

  int sel = 0;
  int cur_d = 10;
  int stall_pct = 0;
  int cyc = 0;

  // Reference model state for the selected instance.
  bit         mbits[$];
  logic [7:0] mbytes[$];
  int         mcount;

  // Log of bytes actually transferred since the last reset.
  logic [7:0] got_bytes[$];
  bit         got_last[$];
  int         got_cyc[$];

  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compress_q(x, d) straight from its definition.
  function automatic int compress(input int x, input int d);
    longint n = (longint'(x) << d) + 64'd1664;
    return int'((n / 64'd3329) % (64'd1 << d));
  endfunction

  function automatic int count_lasts();
    int n = 0;
    foreach (got_last[i]) if (got_last[i]) n++;
    return n;
  endfunction

  always @(posedge clk) cyc++;

  // Consumer: out_ready low on stall_pct percent of cycles.
  initial begin
    out_ready = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        out_ready[i] = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Compare process: sampled on the falling edge, so every value seen here
  // is what the next rising edge will act on.
  always @(negedge clk) begin
    int c;
    logic [7:0] v;
    if (rst) begin
      mbits.delete();
      mbytes.delete();
      mcount = 0;
      got_bytes.delete();
      got_last.delete();
      got_cyc.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid[sel], 1);
        check("stall_byte_held", out_byte[sel], prev_byte);
        check("stall_last_held", out_last[sel], prev_last);
      end
      if (out_valid[sel]) begin
        check("byte_available", mbytes.size() > 0, 1);
        if (mbytes.size() > 0) check("out_byte", out_byte[sel], mbytes[0]);
        check("out_last", out_last[sel],
              (mcount % (32 * cur_d)) == (32 * cur_d - 1));
      end else begin
        check("last_low_when_idle", out_last[sel], 0);
      end
      if (out_valid[sel] && out_ready[sel]) begin
        got_bytes.push_back(out_byte[sel]);
        got_last.push_back(out_last[sel]);
        got_cyc.push_back(cyc);
        if (mbytes.size() > 0) void'(mbytes.pop_front());
        mcount++;
      end
      prev_stall = out_valid[sel] && !out_ready[sel];
      prev_byte  = out_byte[sel];
      prev_last  = out_last[sel];
      if (in_valid[sel] && in_ready[sel]) begin
        c = compress(int'(in_coef[sel]), cur_d);
        for (int b = 0; b < cur_d; b++) mbits.push_back(bit'((c >> b) & 1));
        while (mbits.size() >= 8) begin
          for (int b = 0; b < 8; b++) v[b] = mbits.pop_front();
          mbytes.push_back(v);
        end
      end
    end
  end

  task automatic do_reset(input int s);
    @(posedge clk);
    #1;
    sel      = s;
    cur_d    = DS[s];
    in_valid = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid[sel], 0);
    check("rst_out_last", out_last[sel], 0);
    check("rst_out_byte", out_byte[sel], 0);
    check("rst_in_ready", in_ready[sel], 1);
  endtask

  // Offer one coefficient (after up to max_gap idle cycles) until accepted.
  task automatic push(input int x, input int max_gap);
    int  n = 0;
    bit  acc = 1'b0;
    repeat ($urandom_range(0, max_gap)) begin
      @(posedge clk);
      #1;
    end
    in_valid[sel] = 1'b1;
    in_coef[sel]  = 12'(x);
    do begin
      @(negedge clk);
      acc = in_ready[sel];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check("push_accepted", acc, 1);
    in_valid[sel] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mbytes.size() > 0 || mbits.size() > 0) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", mbytes.size() + mbits.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_drain", out_valid[sel], 0);
  endtask

  initial begin
    int nz;
    rst      = 1'b1;
    in_valid = '0;
    in_coef  = '0;

    // Pin the model against hand-computed values.
    check("model_501_d10", compress(501, 10), 154);
    check("model_2497_d1", compress(2497, 1), 0);
    check("model_1665_d4", compress(1665, 4), 8);
    check("model_4095_d11", compress(4095, 11), 471);

    // D=10: single nonzero coefficient 501 followed by zeros.
    do_reset(0);
    stall_pct = 0;
    push(501, 0);
    for (int i = 1; i < 256; i++) push(0, 0);
    drain();
    check("d10_len", got_bytes.size(), 320);
    check("d10_byte0", got_bytes[0], 8'h9A);
    check("d10_byte1", got_bytes[1], 8'h00);
    nz = 0;
    for (int i = 2; i < got_bytes.size(); i++) if (got_bytes[i] != 8'h00) nz++;
    check("d10_rest_zero", nz, 0);
    check("d10_last_pos", got_last[319], 1);
    check("d10_last_count", count_lasts(), 1);

    // D=10 latency: empty packer, consumer ready.
    do_reset(0);
    push(1000, 0);
    check("lat_not_yet", out_valid[sel], 0);
    @(posedge clk);
    #1;
    check("lat_valid_k1", out_valid[sel], 1);

    // D=1: rounding boundaries around q/4 and 3q/4.
    do_reset(1);
    push(832, 0);
    push(833, 0);
    push(1665, 0);
    push(2496, 0);
    push(2497, 0);
    push(3328, 0);
    push(0, 0);
    push(0, 0);
    drain();
    check("d1_len", got_bytes.size(), 1);
    check("d1_byte0", got_bytes[0], 8'h0E);
    check("d1_no_last", got_last[0], 0);

    // D=4: two blocks, 1665 then 3328.
    do_reset(2);
    for (int i = 0; i < 256; i++) push(1665, 0);
    drain();
    nz = 0;
    foreach (got_bytes[i]) if (got_bytes[i] != 8'h88) nz++;
    check("d4_len_a", got_bytes.size(), 128);
    check("d4_all_88", nz, 0);
    check("d4_last_a", got_last[127], 1);
    check("d4_lasts_a", count_lasts(), 1);
    for (int i = 0; i < 256; i++) push(3328, 0);
    drain();
    nz = 0;
    for (int i = 128; i < got_bytes.size(); i++) if (got_bytes[i] != 8'h00) nz++;
    check("d4_len_b", got_bytes.size(), 256);
    check("d4_all_00", nz, 0);
    check("d4_last_b", got_last[255], 1);
    check("d4_lasts_b", count_lasts(), 2);

    // D=10: random coefficients (raw 12-bit), random gaps, 50% stalls.
    do_reset(0);
    stall_pct = 50;
    push(4095, 2);
    push(3329, 2);
    for (int i = 2; i < 256; i++) push(int'($urandom_range(0, 4095)), 2);
    drain();
    check("rnd10_len", got_bytes.size(), 320);
    check("rnd10_last_pos", got_last[319], 1);
    check("rnd10_lasts", count_lasts(), 1);

    // D=11: two blocks back-to-back, consumer always ready.
    do_reset(3);
    stall_pct = 0;
    for (int i = 0; i < 512; i++) push(int'($urandom_range(0, 4095)), 0);
    drain();
    check("d11_len", got_bytes.size(), 704);
    check("d11_last_352", got_last[351], 1);
    check("d11_last_704", got_last[703], 1);
    check("d11_lasts", count_lasts(), 2);
    check("d11_no_gap", got_cyc[703] - got_cyc[0], 703);

    // D=5: random coefficients with 30% stalls.
    do_reset(4);
    stall_pct = 30;
    for (int i = 0; i < 256; i++) push(int'($urandom_range(0, 4095)), 1);
    drain();
    check("d5_len", got_bytes.size(), 160);
    check("d5_last_pos", got_last[159], 1);
    check("d5_lasts", count_lasts(), 1);

    // D=10: reset mid-block, then a fresh block.
    do_reset(0);
    stall_pct = 50;
    for (int i = 0; i < 100; i++) push(int'($urandom_range(0, 4095)), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid[sel], 0);
    check("midrst_in_ready", in_ready[sel], 1);
    for (int i = 0; i < 256; i++) push(int'($urandom_range(0, 4095)), 1);
    drain();
    check("midrst_len", got_bytes.size(), 320);
    check("midrst_last_pos", got_last[319], 1);
    check("midrst_lasts", count_lasts(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
